// File: rtl/pop_reader_pkg.sv
// Shared defaults, index width and FSM encoding for the population reader.
// Optional build macro: POP_READER_PARITY_EN (adds ind_parity).
package pop_reader_pkg;

  localparam int POP_BITS_D  = 7500;
  localparam int GENE_BITS_D = 75;
  localparam int NUM_IND_D   = 100;
  localparam int IDX_W       = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic xor_red(
    input logic [GENE_BITS_D-1:0] v
  );
    return ^v;
  endfunction

endpackage

// File: rtl/pop_reader_if.sv
// Individual stream handshake between the population reader and a consumer.
// Optional build macro: POP_READER_PARITY_EN (adds ind_parity).
interface pop_reader_if
  import pop_reader_pkg::*;
#(
  parameter int GENE_BITS = GENE_BITS_D
) ();

  logic [GENE_BITS-1:0] ind_data;
  logic [IDX_W-1:0]     ind_index;
  logic                 ind_valid;
  logic                 ind_ready;
`ifdef POP_READER_PARITY_EN
  logic                 ind_parity;

  modport master (
    output ind_data,
    output ind_index,
    output ind_valid,
    output ind_parity,
    input  ind_ready
  );

  modport slave (
    input  ind_data,
    input  ind_index,
    input  ind_valid,
    input  ind_parity,
    output ind_ready
  );
`else
  modport master (
    output ind_data,
    output ind_index,
    output ind_valid,
    input  ind_ready
  );

  modport slave (
    input  ind_data,
    input  ind_index,
    input  ind_valid,
    output ind_ready
  );
`endif

endinterface

// File: rtl/pop_shift_reg.sv
// Population capture register: parallel load, left shift by one individual.
// Optional build macro: none used here (POP_READER_PARITY_EN is top-level).
module pop_shift_reg #(
  parameter int WIDTH = 7500,
  parameter int STEP  = 75
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic [STEP-1:0]  top
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {q[WIDTH-STEP-1:0], {STEP{1'b0}}};
    end
  end

  assign top = q[WIDTH-1 -: STEP];

endmodule

// File: rtl/pop_reader.sv
// Streams a captured population out one individual per handshake.
// Optional build macro: POP_READER_PARITY_EN adds bus.ind_parity.
module pop_reader
  import pop_reader_pkg::*;
#(
  parameter int POP_BITS  = POP_BITS_D,
  parameter int GENE_BITS = GENE_BITS_D,
  parameter int NUM_IND   = NUM_IND_D
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [POP_BITS-1:0] population,
  pop_reader_if.master        bus,
  output logic                busy,
  output logic                done
);

  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(NUM_IND - 1);

  state_t               state;
  state_t               state_nx;
  logic [IDX_W-1:0]     idx;
  logic                 load;
  logic                 xfer;
  logic [GENE_BITS-1:0] top;
  logic [GENE_BITS-1:0] data;

  pop_shift_reg #(
    .WIDTH (POP_BITS),
    .STEP  (GENE_BITS)
  ) u_sreg (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (xfer),
    .din   (population),
    .top   (top)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (load) begin
      idx <= '0;
    end else if (xfer) begin
      idx <= idx + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    xfer     = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        if (start) begin
          load     = 1'b1;
          state_nx = EMIT;
        end
      end
      (state == EMIT): begin
        busy = 1'b1;
        xfer = bus.ind_ready;
        if (xfer && idx == LAST) begin
          state_nx = DONE;
        end
      end
      (state == DONE): begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Data is gated so nothing leaks out of the register outside EMIT.
  assign data          = busy ? top : '0;
  assign bus.ind_data  = data;
  assign bus.ind_index = idx;
  assign bus.ind_valid = busy;

`ifdef POP_READER_PARITY_EN
  assign bus.ind_parity = ^data;
`endif

endmodule

// File: tb/tb_pop_reader.sv
// Scoreboard bench for pop_reader with a randomized reference model.
// Optional build macro: POP_READER_PARITY_EN enables parity checks.
module tb_pop_reader;
  import pop_reader_pkg::*;

  localparam int GB = GENE_BITS_D;
  localparam int NI = NUM_IND_D;
  localparam int PB = POP_BITS_D;

  typedef struct {
    logic [GB-1:0] data;
    int            idx;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [PB-1:0] population;
  logic          busy;
  logic          done;

  pop_reader_if #(.GENE_BITS(GB)) bus ();

  pop_reader #(
    .POP_BITS  (PB),
    .GENE_BITS (GB),
    .NUM_IND   (NI)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .population (population),
    .bus        (bus.master),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  exp_t          sbq[$];
  logic [GB-1:0] ind[NI];
  int            n_chk = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            exp_done_cyc = 0;
  bit            lat_on = 1'b0;
  bit            seen_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [127:0] act,
                     logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               nm, act, req, cyc);
    end
  endtask

  function automatic logic [GB-1:0] rnd_ind();
    return GB'({$urandom(), $urandom(), $urandom()});
  endfunction

  task automatic pack_pop();
    for (int i = 0; i < NI; i++)
      population[(NI-1-i)*GB +: GB] = ind[i];
  endtask

  task automatic scramble_pop();
    for (int i = 0; i < NI; i++)
      population[(NI-1-i)*GB +: GB] = rnd_ind();
  endtask

  task automatic rnd_model();
    for (int i = 0; i < NI; i++) ind[i] = rnd_ind();
  endtask

  task automatic push_run();
    for (int i = 0; i < NI; i++)
      sbq.push_back('{data: ind[i], idx: i});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every presented transfer with the queue head.
  logic [GB-1:0] pd;
  logic [6:0]    pi;
  bit            pstall = 1'b0;
  bit            pdone = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      pstall = 1'b0;
      pdone  = 1'b0;
    end else begin
      if (bus.ind_valid) begin
        chk("busy_in_emit", busy, 1);
        if (pstall) begin
          chk("hold_data", bus.ind_data, pd);
          chk("hold_index", bus.ind_index, pi);
        end
        if (bus.ind_ready) begin
          if (sbq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_xfer: got idx %0d expected none",
                     bus.ind_index);
          end else begin
            e = sbq.pop_front();
            chk("ind_data", bus.ind_data, e.data);
            chk("ind_index", bus.ind_index, e.idx);
`ifdef POP_READER_PARITY_EN
            chk("ind_parity", bus.ind_parity, ^e.data);
`endif
          end
        end
      end else begin
        chk("busy_outside_emit", busy, 0);
        if (!done) begin
          chk("idle_data_zero", bus.ind_data, 0);
`ifdef POP_READER_PARITY_EN
          chk("idle_parity_zero", bus.ind_parity, 0);
`endif
        end
      end
      if (done) begin
        chk("done_after_last", sbq.size(), 0);
        chk("done_one_cycle", pdone, 0);
        if (lat_on) chk("done_latency", cyc, exp_done_cyc);
        seen_done = 1'b1;
      end
      pstall = bus.ind_valid && !bus.ind_ready;
      pd     = bus.ind_data;
      pi     = bus.ind_index;
      pdone  = done;
    end
  end

  // mode 0: ready high, 1: ready toggles 1,0, 2: random + perturbation
  task automatic run(int mode);
    int c;
    bit tog;
    pack_pop();
    seen_done = 1'b0;
    lat_on = (mode == 0);
    exp_done_cyc = cyc + 1 + NI;
    start = 1'b1;
    bus.ind_ready = 1'b1;
    push_run();
    step();
    start = 1'b0;
    c = 0;
    tog = 1'b1;
    while (!seen_done && c < 1000) begin
      unique case (mode)
        0: bus.ind_ready = 1'b1;
        1: begin
          bus.ind_ready = tog;
          tog = ~tog;
        end
        default: begin
          bus.ind_ready = 1'($urandom_range(0, 1));
          start = ($urandom_range(0, 5) == 0);
          if ($urandom_range(0, 3) == 0) scramble_pop();
        end
      endcase
      step();
      c++;
    end
    start = 1'b0;
    if (!seen_done) begin
      n_chk++;
      n_fail++;
      $display("FAIL run_timeout: got no done expected done (mode %0d)",
               mode);
    end
    step();
  endtask

  initial begin
    int c;
    rst = 1'b1;
    start = 1'b0;
    bus.ind_ready = 1'b0;
    population = '0;
    repeat (3) step();
    chk("rst_valid", bus.ind_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data", bus.ind_data, 0);
    chk("rst_index", bus.ind_index, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < NI; i++) ind[i] = GB'(i);
    run(0);
    run(1);

    for (int k = 0; k < 3; k++) begin
      rnd_model();
      run(2);
    end

    rnd_model();
    pack_pop();
    seen_done = 1'b0;
    lat_on = 1'b0;
    start = 1'b1;
    push_run();
    step();
    start = 1'b0;
    c = 0;
    while (bus.ind_index != 7'd37 && c < 500) begin
      bus.ind_ready = 1'($urandom_range(0, 1));
      step();
      c++;
    end
    chk("reached_idx37", bus.ind_index, 37);
    rst = 1'b1;
    bus.ind_ready = 1'b1;
    start = 1'b1;
    step();
    chk("midrst_valid", bus.ind_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_index", bus.ind_index, 0);
    chk("midrst_done", done, 0);
    sbq.delete();
    rst = 1'b0;
    start = 1'b0;
    step();
    rnd_model();
    run(0);

`ifdef POP_READER_PARITY_EN
    rnd_model();
    ind[5] = GB'(1);
    ind[6] = GB'(3);
    run(0);
`endif

    chk("queue_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
